// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan path
package seg_pkg;
    localparam int NUM_DIGITS = 8;
    localparam logic [7:0] ANODE_OFF = 8'hFF;
    typedef struct packed {
        logic       en;
        logic       dp;
        logic [3:0] val;
    } digit_t;
    typedef enum logic {BLANK, DRIVE} state_t;
endpackage

// File: rtl/seg_scan_controller_slot_timer.sv
// slot_timer: per-digit prescaler with end-of-slot and end-of-blanking strobes
module slot_timer #(
    parameter int DIV = 131072,
    parameter int BLANK_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end,
    output logic blank_end
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt;
    assign slot_end = cnt == CW'(DIV - 1);
    assign blank_end = cnt == CW'(BLANK_CYC - 1);
    always_ff @(posedge clk)
        cnt <= (rst || slot_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: double-buffered 8-digit scan sequencer with inter-digit blanking
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int DIV = 131072,
    parameter int BLANK_CYC = 1024
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Wr_En,
    input  logic [2:0] Wr_Addr,
    input  logic [5:0] Wr_Data,
    input  logic       Commit,
    output logic [7:0] Anode,
    output logic [3:0] Bin,
    output logic       Dp,
    output logic       Frame_Tick,
    output logic       Commit_Pending
);
    state_t state, state_d;
    digit_t shadow [NUM_DIGITS];
    digit_t active [NUM_DIGITS];
    digit_t cur;
    logic [2:0] idx;
    logic [7:0] anode_d;
    logic slot_end, blank_end, frame_end;

    slot_timer #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) u_timer (
        .clk(Clk),
        .rst(Reset),
        .slot_end(slot_end),
        .blank_end(blank_end)
    );

    assign frame_end = slot_end && idx == 3'd7;
    assign cur = active[idx];

    always_comb begin
        state_d = state;
        anode_d = ANODE_OFF;
        state_d = (state == BLANK) ? (blank_end ? DRIVE : BLANK) : (slot_end ? BLANK : DRIVE);
        anode_d = (state == DRIVE && cur.en) ? ~(8'd1 << idx) : ANODE_OFF;
    end

    // Copy reads shadow before this edge's write lands, so a boundary write waits a frame
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= BLANK;
            idx <= '0;
            shadow <= '{default: '0};
            active <= '{default: '0};
            Commit_Pending <= 1'b0;
            Anode <= ANODE_OFF;
            Bin <= '0;
            Dp <= 1'b1;
            Frame_Tick <= 1'b0;
        end else begin
            state <= state_d;
            if (slot_end) idx <= idx + 1'b1;
            if (Wr_En) shadow[Wr_Addr] <= digit_t'(Wr_Data);
            if (frame_end && Commit_Pending) active <= shadow;
            Commit_Pending <= frame_end ? (!Commit_Pending && Commit) : (Commit_Pending || Commit);
            Anode <= anode_d;
            Bin <= cur.val;
            Dp <= ~cur.dp;
            Frame_Tick <= frame_end;
        end
    end
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: randomized and directed checks against a position-based reference model
module tb_seg_scan_controller;
    localparam int DIV = 8, BLANK = 2, FRAME = 64;
    logic Clk = 0, Reset = 1, Wr_En = 0, Commit = 0;
    logic [2:0] Wr_Addr = 0;
    logic [5:0] Wr_Data = 0;
    logic [7:0] Anode;
    logic [3:0] Bin;
    logic Dp, Frame_Tick, Commit_Pending;
    int checks = 0, failures = 0;
    logic [5:0] m_shadow [8];
    logic [5:0] m_active [8];
    logic m_pend;
    int n;
    logic [2:0] m_c, m_d;
    logic m_b;
    logic [7:0] e_anode;
    logic [3:0] e_bin;
    logic e_dp, e_tick;

    seg_scan_controller #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .Clk(Clk), .Reset(Reset), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
        .Commit(Commit), .Anode(Anode), .Bin(Bin), .Dp(Dp), .Frame_Tick(Frame_Tick),
        .Commit_Pending(Commit_Pending)
    );

    always #5 Clk = ~Clk;

    // n counts cycles since reset release; slot and digit follow by division
    always_comb begin
        m_c = 3'(n % DIV);
        m_d = 3'((n / DIV) % 8);
        m_b = m_c == 3'(DIV - 1) && m_d == 3'd7;
    end

    always @(posedge Clk) begin
        if (Reset) begin
            n <= 0;
            m_pend <= 1'b0;
            m_shadow <= '{default: '0};
            m_active <= '{default: '0};
            e_anode <= 8'hFF;
            e_bin <= 4'h0;
            e_dp <= 1'b1;
            e_tick <= 1'b0;
        end else begin
            n <= n + 1;
            e_anode <= (m_c >= 3'(BLANK) && m_active[m_d][5]) ? ~(8'd1 << m_d) : 8'hFF;
            e_bin <= m_active[m_d][3:0];
            e_dp <= ~m_active[m_d][4];
            e_tick <= m_b;
            if (m_b && m_pend) m_active <= m_shadow;
            m_pend <= m_b ? (!m_pend && Commit) : (m_pend || Commit);
            if (Wr_En) m_shadow[Wr_Addr] <= Wr_Data;
        end
    end

    task automatic drive_wr(input logic [2:0] a, input logic [5:0] d);
        @(negedge Clk);
        Wr_En = 1; Wr_Addr = a; Wr_Data = d;
        @(negedge Clk);
        Wr_En = 0;
    endtask

    task automatic drive_commit();
        @(negedge Clk);
        Commit = 1;
        @(negedge Clk);
        Commit = 0;
    endtask

    task automatic test_reset();
        int ticks = 0;
        Reset = 1;
        repeat (3) @(negedge Clk);
        checks++;
        if ({Anode, Bin, Dp, Frame_Tick, Commit_Pending} !== {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got=%h want=%h", {Anode, Bin, Dp, Frame_Tick, Commit_Pending}, {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0});
        end
        Reset = 0;
        for (int i = 0; i < 130; i++) begin
            @(negedge Clk);
            checks++;
            if ({Anode, Bin, Dp, Frame_Tick, Commit_Pending} !== {e_anode, e_bin, e_dp, e_tick, m_pend}) begin
                failures++;
                $display("FAIL idle_model: got=%h want=%h", {Anode, Bin, Dp, Frame_Tick, Commit_Pending}, {e_anode, e_bin, e_dp, e_tick, m_pend});
            end
            checks++;
            if (Anode !== 8'hFF) begin
                failures++;
                $display("FAIL idle_anode: got=%h want=ff", Anode);
            end
            ticks += int'(Frame_Tick);
        end
        checks++;
        if (ticks != 2) begin
            failures++;
            $display("FAIL idle_ticks: got=%0d want=2", ticks);
        end
    endtask

    task automatic test_scan();
        int q;
        for (int i = 0; i < 8; i++) drive_wr(3'(i), 6'h20 | 6'(i));
        drive_commit();
        checks++;
        if (Commit_Pending !== 1'b1) begin
            failures++;
            $display("FAIL scan_pending_set: got=%b want=1", Commit_Pending);
        end
        do begin
            @(negedge Clk);
            checks++;
            if ({Anode, Bin, Dp, Frame_Tick, Commit_Pending} !== {e_anode, e_bin, e_dp, e_tick, m_pend}) begin
                failures++;
                $display("FAIL scan_wait: got=%h want=%h", {Anode, Bin, Dp, Frame_Tick, Commit_Pending}, {e_anode, e_bin, e_dp, e_tick, m_pend});
            end
        end while (n % FRAME != 0);
        checks++;
        if (Commit_Pending !== 1'b0) begin
            failures++;
            $display("FAIL scan_pending_clear: got=%b want=0", Commit_Pending);
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge Clk);
            q = n - 1;
            checks++;
            if (Anode !== ((q % DIV >= BLANK) ? ~(8'd1 << ((q / DIV) % 8)) : 8'hFF) || Bin !== 4'((q / DIV) % 8)) begin
                failures++;
                $display("FAIL scan_digit: pos=%0d got anode=%h bin=%h", q, Anode, Bin);
            end
            checks++;
            if ({Anode, Bin, Dp, Frame_Tick, Commit_Pending} !== {e_anode, e_bin, e_dp, e_tick, m_pend}) begin
                failures++;
                $display("FAIL scan_model: got=%h want=%h", {Anode, Bin, Dp, Frame_Tick, Commit_Pending}, {e_anode, e_bin, e_dp, e_tick, m_pend});
            end
        end
    endtask

    task automatic test_disable();
        int q;
        drive_wr(3'd3, 6'h03);
        drive_commit();
        do begin
            @(negedge Clk);
            checks++;
            if ({Anode, Bin, Dp, Frame_Tick, Commit_Pending} !== {e_anode, e_bin, e_dp, e_tick, m_pend}) begin
                failures++;
                $display("FAIL disable_wait: got=%h want=%h", {Anode, Bin, Dp, Frame_Tick, Commit_Pending}, {e_anode, e_bin, e_dp, e_tick, m_pend});
            end
        end while (n % FRAME != 0);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge Clk);
            q = n - 1;
            checks++;
            if ({Anode, Bin, Dp, Frame_Tick, Commit_Pending} !== {e_anode, e_bin, e_dp, e_tick, m_pend}) begin
                failures++;
                $display("FAIL disable_model: got=%h want=%h", {Anode, Bin, Dp, Frame_Tick, Commit_Pending}, {e_anode, e_bin, e_dp, e_tick, m_pend});
            end
            if ((q / DIV) % 8 == 3) begin
                checks++;
                if (Anode !== 8'hFF) begin
                    failures++;
                    $display("FAIL disable_dark: pos=%0d got=%h want=ff", q, Anode);
                end
            end
        end
    endtask

    task automatic test_boundary();
        int k, q;
        for (int i = 0; i < 200 && n % FRAME != FRAME - 1; i++) @(negedge Clk);
        checks++;
        if (n % FRAME != FRAME - 1 || Commit_Pending !== 1'b0) begin
            failures++;
            $display("FAIL boundary_setup: pos=%0d pending=%b want pos%%64=63 pending=0", n, Commit_Pending);
        end
        Wr_En = 1; Wr_Addr = 3'd5; Wr_Data = 6'h2A; Commit = 1;
        @(negedge Clk);
        Wr_En = 0; Commit = 0;
        k = n / FRAME;
        for (int i = 0; i < 129; i++) begin
            if (i > 0) @(negedge Clk);
            q = n - 1;
            checks++;
            if ({Anode, Bin, Dp, Frame_Tick, Commit_Pending} !== {e_anode, e_bin, e_dp, e_tick, m_pend}) begin
                failures++;
                $display("FAIL boundary_model: got=%h want=%h", {Anode, Bin, Dp, Frame_Tick, Commit_Pending}, {e_anode, e_bin, e_dp, e_tick, m_pend});
            end
            checks++;
            if (Commit_Pending !== (n < FRAME * k + FRAME)) begin
                failures++;
                $display("FAIL boundary_pending: pos=%0d got=%b want=%b", q, Commit_Pending, n < FRAME * k + FRAME);
            end
            if ((q / DIV) % 8 == 5 && q >= FRAME * k) begin
                checks++;
                if (Bin !== (q < FRAME * (k + 1) ? 4'h5 : 4'hA)) begin
                    failures++;
                    $display("FAIL boundary_digit5: pos=%0d got=%h want=%h", q, Bin, q < FRAME * (k + 1) ? 4'h5 : 4'hA);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 200 && n % FRAME != 1; i++) @(negedge Clk);
        Commit = 1;
        @(negedge Clk);
        Commit = 0;
        for (int i = 0; i < 200 && n % FRAME != 4 * DIV + 4; i++) @(negedge Clk);
        checks++;
        if (Commit_Pending !== 1'b1 || Anode === 8'hFF) begin
            failures++;
            $display("FAIL midreset_setup: pending=%b anode=%h want pending=1 anode lit", Commit_Pending, Anode);
        end
        Reset = 1;
        @(negedge Clk);
        checks++;
        if ({Anode, Bin, Dp, Frame_Tick, Commit_Pending} !== {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_state: got=%h want=%h", {Anode, Bin, Dp, Frame_Tick, Commit_Pending}, {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0});
        end
        Reset = 0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge Clk);
            checks++;
            if (Frame_Tick !== (i == FRAME) || Anode !== 8'hFF || Commit_Pending !== 1'b0) begin
                failures++;
                $display("FAIL midreset_restart: cyc=%0d got tick=%b anode=%h pend=%b", i, Frame_Tick, Anode, Commit_Pending);
            end
            checks++;
            if ({Anode, Bin, Dp, Frame_Tick, Commit_Pending} !== {e_anode, e_bin, e_dp, e_tick, m_pend}) begin
                failures++;
                $display("FAIL midreset_model: got=%h want=%h", {Anode, Bin, Dp, Frame_Tick, Commit_Pending}, {e_anode, e_bin, e_dp, e_tick, m_pend});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10 * FRAME; i++) begin
            @(negedge Clk);
            checks++;
            if ({Anode, Bin, Dp, Frame_Tick, Commit_Pending} !== {e_anode, e_bin, e_dp, e_tick, m_pend}) begin
                failures++;
                $display("FAIL random_model: got=%h want=%h", {Anode, Bin, Dp, Frame_Tick, Commit_Pending}, {e_anode, e_bin, e_dp, e_tick, m_pend});
            end
            checks++;
            if ($countones(~Anode) > 1) begin
                failures++;
                $display("FAIL random_onehot: got=%h want at most one low bit", Anode);
            end
            Wr_En = ($urandom % 3) == 0;
            Wr_Addr = 3'($urandom);
            Wr_Data = 6'($urandom);
            Commit = ($urandom % 40) == 0;
        end
        @(negedge Clk);
        Wr_En = 0; Commit = 0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_disable();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
